// File: rtl/ice_cream_dispense_arbiter.sv
// ice_cream_dispense_arbiter
//   Shares one ball dispenser between two coin front-ends. A pending request
//   is granted round-robin once the stock can cover it. The block then issues
//   one drop pulse per ball, waits for the mechanism-done handshake after each
//   drop, and finally pulses ack to the owner. It also tracks stock with
//   saturating refills and latches a sticky fault if the mechanism stalls.
//
// Optional feature macro: SOLD_OUT_REFUND_EN
//   defined   : an under-stocked request is still granted, but it is answered
//               with ack+refund and no drop.
//   undefined : an under-stocked request waits for a refill; refund is tied 0.
//
// Ports
//   clk        clock
//   reset      synchronous, active-high reset
//   req[1:0]   request level from front-end i, held until ack[i]
//   balls0/1   balls requested by front-end 0/1 (3 is treated as 2)
//   mech_done  dispenser finished the current ball (1-cycle pulse)
//   refill     adds REFILL_QTY balls, saturating at STOCK_MAX
//   drop       1-cycle pulse: dispense one ball
//   grant[1:0] one-hot owner while a service is in progress, else 0
//   ack[1:0]   1-cycle completion pulse to the owner
//   refund[1:0] qualifies ack: request refused for lack of stock
//   busy       arbiter is not idle
//   stock      current ball count
//   fault      mechanism timeout, sticky until reset
module ice_cream_dispense_arbiter #(
  parameter int STOCK_W    = 6,
  parameter int STOCK_INIT = 16,
  parameter int STOCK_MAX  = 63,
  parameter int REFILL_QTY = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req,
  input  logic [1:0]         balls0,
  input  logic [1:0]         balls1,
  input  logic               mech_done,
  input  logic               refill,
  output logic               drop,
  output logic [1:0]         grant,
  output logic [1:0]         ack,
  output logic [1:0]         refund,
  output logic               busy,
  output logic [STOCK_W-1:0] stock,
  output logic               fault
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DROP  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [2:0]         state_q, state_d;
  logic [STOCK_W-1:0] stock_q, stock_d;
  logic               rr_q, rr_d;
  logic [1:0]         grant_q, grant_d;
  logic [1:0]         remaining_q, remaining_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic [1:0] balls_in [2];
  logic [1:0] eff      [2];
  logic [1:0] enough;
  logic [1:0] eligible;
  logic       pick;

  assign balls_in[0] = balls0;
  assign balls_in[1] = balls1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign eff[gi]    = (balls_in[gi] == 2'd3) ? 2'd2 : balls_in[gi];
    assign enough[gi] = (STOCK_W'(eff[gi]) <= stock_q);
`ifdef SOLD_OUT_REFUND_EN
    assign eligible[gi] = req[gi];
`else
    assign eligible[gi] = req[gi] & enough[gi];
`endif
  end

  // Requester 1 wins when it is the only candidate or when the round-robin
  // pointer favours it in a tie.
  assign pick = eligible[1] & (~eligible[0] | rr_q);

`ifdef SOLD_OUT_REFUND_EN
  logic refund_q, refund_d;
  logic short_pick;
  assign short_pick = ~enough[pick];
`endif

  // Stock update: refill and drop can coincide; widen by one bit so the sum
  // cannot wrap before saturation.
  logic [STOCK_W:0] stock_sum;
  always_comb begin
    stock_sum = {1'b0, stock_q};
    if (refill) begin
      stock_sum = stock_sum + (STOCK_W+1)'(REFILL_QTY);
    end
    if (state_q == ST_DROP) begin
      stock_sum = stock_sum - (STOCK_W+1)'(1);
    end
    if (stock_sum > (STOCK_W+1)'(STOCK_MAX)) begin
      stock_d = STOCK_W'(STOCK_MAX);
    end else begin
      stock_d = stock_sum[STOCK_W-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    remaining_d = remaining_q;
    wait_cnt_d  = wait_cnt_q;
`ifdef SOLD_OUT_REFUND_EN
    refund_d    = refund_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          grant_d     = pick ? 2'b10 : 2'b01;
          remaining_d = eff[pick];
`ifdef SOLD_OUT_REFUND_EN
          refund_d    = short_pick;
          state_d     = (short_pick || eff[pick] == 2'd0) ? ST_ACK : ST_DROP;
`else
          state_d     = (eff[pick] == 2'd0) ? ST_ACK : ST_DROP;
`endif
        end
      end
      ST_DROP: begin
        // mech_done is deliberately not looked at here.
        remaining_d = remaining_q - 2'd1;
        wait_cnt_d  = '0;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        // A done pulse in the last allowed cycle still counts as on time.
        if (mech_done) begin
          state_d = (remaining_q != 2'd0) ? ST_DROP : ST_ACK;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_ACK: begin
        // Hand the tie-break to whoever was not just served.
        rr_d    = grant_q[0];
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      stock_q     <= STOCK_W'(STOCK_INIT);
      rr_q        <= 1'b0;
      grant_q     <= 2'b00;
      remaining_q <= 2'd0;
      wait_cnt_q  <= '0;
`ifdef SOLD_OUT_REFUND_EN
      refund_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      stock_q     <= stock_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      remaining_q <= remaining_d;
      wait_cnt_q  <= wait_cnt_d;
`ifdef SOLD_OUT_REFUND_EN
      refund_q    <= refund_d;
`endif
    end
  end

  // All outputs are decoded from registered state only.
  assign drop  = (state_q == ST_DROP);
  assign grant = (state_q == ST_DROP || state_q == ST_WAIT || state_q == ST_ACK) ? grant_q : 2'b00;
  assign ack   = (state_q == ST_ACK) ? grant_q : 2'b00;
  assign busy  = (state_q != ST_IDLE);
  assign fault = (state_q == ST_FAULT);
  assign stock = stock_q;
`ifdef SOLD_OUT_REFUND_EN
  assign refund = (state_q == ST_ACK && refund_q) ? grant_q : 2'b00;
`else
  assign refund = 2'b00;
`endif

endmodule

// File: tb/tb_ice_cream_dispense_arbiter.sv
// Testbench for ice_cream_dispense_arbiter.
// A service-level model (stock arithmetic, who is being served, how many balls
// are left, how long the mechanism has been silent) predicts every output each
// cycle. Directed scenarios pin the model with hand-computed values; a random
// phase then exercises arbitration, refills, spurious done pulses and resets.
module tb_ice_cream_dispense_arbiter;
  localparam int STOCK_W    = 6;
  localparam int STOCK_INIT = 16;
  localparam int STOCK_MAX  = 63;
  localparam int REFILL_QTY = 16;
  localparam int TIMEOUT    = 15;

  logic               clk = 1'b0;
  logic               reset;
  logic [1:0]         req, balls0, balls1;
  logic               mech_done, refill;
  logic               drop, busy, fault;
  logic [1:0]         grant, ack, refund;
  logic [STOCK_W-1:0] stock;

  always #5 clk = ~clk;

  ice_cream_dispense_arbiter #(
    .STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT), .STOCK_MAX(STOCK_MAX),
    .REFILL_QTY(REFILL_QTY), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .balls0(balls0), .balls1(balls1),
    .mech_done(mech_done), .refill(refill), .drop(drop), .grant(grant),
    .ack(ack), .refund(refund), .busy(busy), .stock(stock), .fault(fault)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  // ---------------- service-level reference model ----------------
  int m_stock = STOCK_INIT;
  int m_owner = 0;
  int m_left = 0;
  int m_rr = 0;
  int m_waited = 0;
  bit m_dropping = 0, m_waiting = 0, m_acking = 0, m_refund = 0, m_fault = 0;

  function automatic bit m_serving();
    return m_dropping || m_waiting || m_acking;
  endfunction

  task automatic model_step();
    int want [2];
    bit short_of [2];
    bit elig [2];
    int nxt;
    int w;
    if (reset) begin
      m_stock = STOCK_INIT; m_owner = 0; m_left = 0; m_rr = 0; m_waited = 0;
      m_dropping = 0; m_waiting = 0; m_acking = 0; m_refund = 0; m_fault = 0;
      return;
    end
    want[0] = (balls0 == 2'd3) ? 2 : int'(balls0);
    want[1] = (balls1 == 2'd3) ? 2 : int'(balls1);
    for (int i = 0; i < 2; i++) begin
      short_of[i] = want[i] > m_stock;
`ifdef SOLD_OUT_REFUND_EN
      elig[i] = req[i];
`else
      elig[i] = req[i] && !short_of[i];
`endif
    end
    nxt = m_stock + (refill ? REFILL_QTY : 0) - (m_dropping ? 1 : 0);
    if (nxt > STOCK_MAX) nxt = STOCK_MAX;
    if (m_fault) begin
      // stuck until reset
    end else if (m_acking) begin
      m_acking = 0;
      m_rr = 1 - m_owner;
    end else if (m_dropping) begin
      m_dropping = 0;
      m_left--;
      m_waiting = 1;
      m_waited = 0;
    end else if (m_waiting) begin
      if (mech_done) begin
        m_waiting = 0;
        if (m_left > 0) m_dropping = 1; else m_acking = 1;
      end else begin
        m_waited++;
        if (m_waited >= TIMEOUT) begin
          m_waiting = 0;
          m_fault = 1;
        end
      end
    end else if (elig[0] || elig[1]) begin
      if (elig[0] && elig[1]) w = m_rr; else w = elig[1] ? 1 : 0;
      m_owner = w;
      m_left = want[w];
      m_refund = short_of[w];
      if (m_refund || m_left == 0) m_acking = 1; else m_dropping = 1;
    end
    m_stock = nxt;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare and statistics ----------------
  bit cmp_en = 0;
  int n_drop = 0, n_ack0 = 0, n_ack1 = 0, n_refund = 0, n_grant0 = 0, n_grant1 = 0;
  int ack_log [$];

  initial forever begin
    logic [1:0] e_grant, e_ack, e_refund;
    logic       e_busy;
    @(negedge clk);
    if (cmp_en) begin
      e_grant  = m_serving() ? 2'(1 << m_owner) : 2'b00;
      e_ack    = m_acking ? 2'(1 << m_owner) : 2'b00;
      e_refund = (m_acking && m_refund) ? 2'(1 << m_owner) : 2'b00;
      e_busy   = m_serving() || m_fault;
      checks++;
      if (drop !== m_dropping || grant !== e_grant || ack !== e_ack || refund !== e_refund ||
          busy !== e_busy || int'(stock) != m_stock || fault !== m_fault) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t got drop=%0b grant=%b ack=%b refund=%b busy=%0b stock=%0d fault=%0b required drop=%0b grant=%b ack=%b refund=%b busy=%0b stock=%0d fault=%0b",
                 $time, drop, grant, ack, refund, busy, stock, fault,
                 m_dropping, e_grant, e_ack, e_refund, e_busy, m_stock, m_fault);
      end
      if (drop) n_drop++;
      if (ack[0]) begin n_ack0++; ack_log.push_back(0); end
      if (ack[1]) begin n_ack1++; ack_log.push_back(1); end
      if (refund != 2'b00) n_refund++;
      if (grant == 2'b01) n_grant0++;
      if (grant == 2'b10) n_grant1++;
    end
  end

  task automatic clear_stats();
    n_drop = 0; n_ack0 = 0; n_ack1 = 0; n_refund = 0; n_grant0 = 0; n_grant1 = 0;
    ack_log.delete();
  endtask

  // ---------------- stimulus ----------------
  bit rand_mode = 0;
  int mech_mode = 0;        // 0: done one cycle after drop, 1: random delay, 2: never
  int mech_wait = -1;
  bit refill_pulse = 0;
  bit refill_on_drop = 0;

  task automatic step();
    bit dropped [2];
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      dropped[i] = 0;
      if (req[i] && m_acking && m_owner == i) begin
        req[i] = 1'b0;
        dropped[i] = 1;
      end
    end
    if (rand_mode) begin
      for (int i = 0; i < 2; i++) begin
        if (!req[i] && !dropped[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          if (i == 0) balls0 = 2'($urandom_range(0, 3));
          else        balls1 = 2'($urandom_range(0, 3));
        end else if (req[i] && m_owner == i && (m_dropping || m_waiting) && $urandom_range(0, 63) == 0) begin
          req[i] = 1'b0;   // front-end gives up mid-service
        end
      end
    end
    refill = refill_pulse || (rand_mode && $urandom_range(0, 19) == 0);
    refill_pulse = 0;
    if (refill_on_drop && m_dropping) begin
      refill = 1'b1;
      refill_on_drop = 0;
    end
    mech_done = 1'b0;
    if (mech_wait >= 0) begin
      if (mech_wait == 0) begin
        mech_done = 1'b1;
        mech_wait = -1;
      end else begin
        mech_wait--;
      end
    end
    if (m_dropping && mech_mode != 2)
      mech_wait = (mech_mode == 0) ? 0 : $urandom_range(0, 3);
    if (rand_mode && $urandom_range(0, 31) == 0) mech_done = 1'b1;
  endtask

  task automatic do_reset();
    rand_mode = 0; mech_wait = -1; refill_pulse = 0; refill_on_drop = 0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic run_until_idle(string name, int limit);
    int n = 0;
    do begin
      step();
      n++;
    end while ((req != 2'b00 || m_serving()) && n < limit);
    check({name, "_completes"}, (n < limit) ? 1 : 0, 1);
  endtask

  task automatic serve0(logic [1:0] b);
    balls0 = b;
    req = 2'b01;
    run_until_idle("serve0", 60);
  endtask

  initial begin
    int n;
    reset = 1'b1; req = 2'b00; balls0 = 2'd0; balls1 = 2'd0;
    mech_done = 1'b0; refill = 1'b0;
    @(posedge clk);
    cmp_en = 1;
    do_reset();
    check("reset_stock", int'(stock), 16);
    check("reset_outputs", int'({drop, grant, ack, refund, busy, fault}), 0);

    // One front-end, two balls, done one cycle after each drop.
    clear_stats();
    mech_mode = 0;
    serve0(2'd2);
    check("t1_drops", n_drop, 2);
    check("t1_stock", int'(stock), 14);
    check("t1_model_stock", m_stock, 14);
    check("t1_ack0", n_ack0, 1);
    check("t1_grant01_cycles", n_grant0, 5);
    check("t1_grant10_cycles", n_grant1, 0);

    // Simultaneous pair; front-end 0 comes straight back after its ack, so
    // the next tie goes to front-end 1.
    do_reset();
    clear_stats();
    balls0 = 2'd1; balls1 = 2'd1; req = 2'b11;
    n = 0;
    while (!m_acking && n < 30) begin step(); n++; end
    req[0] = 1'b1;
    run_until_idle("t2_pair", 80);
    check("t2_ack_count", ack_log.size(), 3);
    if (ack_log.size() == 3) begin
      check("t2_first", ack_log[0], 0);
      check("t2_second", ack_log[1], 1);
      check("t2_third", ack_log[2], 0);
    end

    // Drain to one ball, then an under-stocked request from front-end 1.
    do_reset();
    for (int k = 0; k < 7; k++) serve0(2'd2);
    serve0(2'd1);
    check("t3_drained_stock", int'(stock), 1);
    clear_stats();
    balls1 = 2'd2; req = 2'b10;
`ifdef SOLD_OUT_REFUND_EN
    run_until_idle("t3_refund", 20);
    check("t3_ack1", n_ack1, 1);
    check("t3_refund", n_refund, 1);
    check("t3_no_drop", n_drop, 0);
    check("t3_stock_kept", int'(stock), 1);
`else
    repeat (20) step();
    check("t3_no_grant", n_grant1, 0);
    check("t3_no_ack", n_ack1, 0);
    check("t3_stock_kept", int'(stock), 1);
    refill_pulse = 1;
    step();
    step();
    check("t3_refilled", int'(stock), 17);
    check("t3_model_refilled", m_stock, 17);
    run_until_idle("t3_serve", 40);
    check("t3_drops", n_drop, 2);
    check("t3_stock_after", int'(stock), 15);
    check("t3_ack1", n_ack1, 1);
`endif

    // Mechanism never answers.
    do_reset();
    clear_stats();
    mech_mode = 2;
    balls0 = 2'd1; req = 2'b01;
    n = 0;
    while (!m_dropping && n < 10) begin step(); n++; end
    n = 0;
    while (!fault && n < 40) begin step(); n++; end
    check("t4_fault_latency", n, TIMEOUT + 1);
    repeat (5) step();
    check("t4_fault_held", int'(fault), 1);
    check("t4_no_ack", n_ack0, 0);
    check("t4_grant_off", int'(grant), 0);
    check("t4_one_drop", n_drop, 1);
    refill_pulse = 1;
    step();
    step();
    check("t4_refill_in_fault", int'(stock), 31);
    mech_mode = 0;
    do_reset();
    check("t4_reset_fault", int'(fault), 0);
    check("t4_reset_stock", int'(stock), 16);
    clear_stats();
    run_until_idle("t4_rearb", 40);
    check("t4_rearb_ack", n_ack0, 1);

    // Saturation, including a refill coinciding with a drop.
    do_reset();
    req = 2'b00;
    refill_pulse = 1; step();
    refill_pulse = 1; step();
    refill_pulse = 1; step();
    step();
    check("t5_saturated", int'(stock), 63);
    serve0(2'd2);
    serve0(2'd1);
    check("t5_stock60", int'(stock), 60);
    clear_stats();
    refill_on_drop = 1;
    serve0(2'd3);
    check("t5_drops", n_drop, 2);
    check("t5_stock_final", int'(stock), 62);
    check("t5_ack0", n_ack0, 1);

    // Random traffic, with a reset dropped in between rounds.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      mech_mode = 1;
      rand_mode = 1;
      repeat (1000) step();
    end
    rand_mode = 0;
    req = 2'b00;
    run_until_idle("drain", 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
